// File: rtl/alu_seq_divider_if.sv
// Request/result and shared-ALU drive bundle for the iterative divider.
interface alu_seq_divider_if #(
    parameter int DATA_W = 31
);
    logic              start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              divZero;
    logic [31:0]       aluSrc1;
    logic [31:0]       aluSrc2;
    logic              invertA;
    logic              invertB;
    logic [1:0]        operation;
    logic [31:0]       aluResult;
    logic              aluZero;
    logic              aluOverflow;

    modport slave (
        input  start, dividend, divisor,
        input  aluResult, aluZero, aluOverflow,
        output busy, done, quotient, remainder, divZero,
        output aluSrc1, aluSrc2, invertA, invertB, operation
    );

    modport master (
        output start, dividend, divisor,
        output aluResult, aluZero, aluOverflow,
        input  busy, done, quotient, remainder, divZero,
        input  aluSrc1, aluSrc2, invertA, invertB, operation
    );
endinterface

// File: rtl/alu_seq_divider.sv
// Unsigned restoring divider; one trial subtraction per clock
// through the shared combinational 32-bit ALU.
module alu_seq_divider #(
    parameter int DATA_W = 31,
    parameter int CNT_W  = 5
) (
    input logic             clk,
    input logic             rst,
    alu_seq_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ITER,
        DONE
    } state_t;

    localparam int PAD = 32 - DATA_W;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] q_r;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo_o;
    logic [DATA_W-1:0] rem_o;
    logic              dz_o;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] q_nx;
    logic              unused_bits;

    assign s = {rem_r[DATA_W-2:0], dvd[cnt]};

    // Only bit 31 (sign) and the low DATA_W bits of the result matter.
    assign unused_bits = ^{bus.aluOverflow, bus.aluResult};

    assign bus.quotient  = quo_o;
    assign bus.remainder = rem_o;
    assign bus.divZero   = dz_o;

    always_comb begin
        rem_nx = s;
        q_nx   = q_r;
        if (!bus.aluResult[31]) begin
            rem_nx = bus.aluResult[DATA_W-1:0];
        end
        q_nx[cnt] = ~bus.aluResult[31];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.aluSrc1   = '0;
        bus.aluSrc2   = '0;
        bus.invertA   = 1'b0;
        bus.invertB   = 1'b0;
        bus.operation = 2'b00;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nx = CHECK;
            end
            CHECK: begin
                bus.busy      = 1'b1;
                bus.aluSrc1   = {{PAD{1'b0}}, dvs};
                bus.operation = 2'b01;
                state_nx      = bus.aluZero ? DONE : ITER;
            end
            ITER: begin
                bus.busy      = 1'b1;
                bus.aluSrc1   = {{PAD{1'b0}}, s};
                bus.aluSrc2   = {{PAD{1'b0}}, dvs};
                bus.invertB   = 1'b1;
                bus.operation = 2'b10;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd   <= '0;
            dvs   <= '0;
            rem_r <= '0;
            q_r   <= '0;
            cnt   <= '0;
            quo_o <= '0;
            rem_o <= '0;
            dz_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd   <= bus.dividend;
                        dvs   <= bus.divisor;
                        rem_r <= '0;
                        q_r   <= '0;
                        quo_o <= '0;
                        rem_o <= '0;
                        dz_o  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (bus.aluZero) begin
                        dz_o  <= 1'b1;
                        quo_o <= '1;
                        rem_o <= dvd;
                    end else begin
                        cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                ITER: begin
                    rem_r <= rem_nx;
                    q_r   <= q_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quo_o <= q_nx;
                        rem_o <= rem_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench: behavioural ALU plus a result scoreboard
// for the iterative divider.
module tb_alu_seq_divider;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [30:0] q;
        logic [30:0] r;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_divider_if #(.DATA_W(31)) bus ();

    alu_seq_divider #(.DATA_W(31), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference 32-bit ALU seen by the divider.
    logic [31:0] alu_a, alu_b, alu_sum, alu_r;
    always_comb begin
        alu_a   = bus.invertA ? ~bus.aluSrc1 : bus.aluSrc1;
        alu_b   = bus.invertB ? ~bus.aluSrc2 : bus.aluSrc2;
        alu_sum = alu_a + alu_b + {31'b0, bus.invertB};
        case (bus.operation)
            2'b00:   alu_r = alu_a & alu_b;
            2'b01:   alu_r = alu_a | alu_b;
            2'b10:   alu_r = alu_sum;
            default: alu_r = {31'b0, alu_sum[31]};
        endcase
        bus.aluResult   = alu_r;
        bus.aluZero     = (alu_r == 32'b0);
        bus.aluOverflow = 1'b0;
    end

    task automatic do_div(input logic [30:0] a, input logic [30:0] b,
                          input int p1, input int p2, input string nm);
        exp_t e;
        exp_t got;
        int   dones;
        int   bad;
        e.dz  = (b == 31'd0);
        e.q   = e.dz ? 31'h7FFFFFFF : a / b;
        e.r   = e.dz ? a : a % b;
        e.lat = e.dz ? 8'd2 : 8'd33;
        dones = 0;
        bad   = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 31'($urandom);
        bus.divisor  = 31'($urandom);
        for (int n = 1; n <= 40; n++) begin
            if (n == 1) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.quotient !== 31'd0 ||
                    bus.remainder !== 31'd0 || bus.divZero !== 1'b0) begin
                    errors++;
                    $display("FAIL %s accept: busy=%b q=%h r=%h dz=%b want busy=1 q=r=0 dz=0",
                             nm, bus.busy, bus.quotient, bus.remainder, bus.divZero);
                end
            end
            if (!e.dz && n >= 2 && n < int'(e.lat)) begin
                if (bus.invertB !== 1'b1 || bus.operation !== 2'b10 ||
                    bus.invertA !== 1'b0 || bus.aluSrc2 !== {1'b0, b} ||
                    bus.busy !== 1'b1)
                    bad++;
            end
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    checks++;
                    if (n != int'(e.lat)) begin
                        errors++;
                        $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s scoreboard: done with no pending entry", nm);
                    end else begin
                        got = sb.pop_front();
                        if (bus.quotient !== got.q || bus.remainder !== got.r ||
                            bus.divZero !== got.dz) begin
                            errors++;
                            $display("FAIL %s result: q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                     nm, bus.quotient, bus.remainder, bus.divZero,
                                     got.q, got.r, got.dz);
                        end
                    end
                end
            end
            if (n == p1 || n == p2) begin
                bus.start    = 1'b1;
                bus.dividend = 31'd1000;
                bus.divisor  = 31'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (n == 40) begin
                checks++;
                if (bus.quotient !== e.q || bus.remainder !== e.r ||
                    bus.divZero !== e.dz || bus.busy !== 1'b0 ||
                    bus.aluSrc1 !== 32'd0 || bus.aluSrc2 !== 32'd0 ||
                    bus.operation !== 2'b00 || bus.invertB !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold: q=%h r=%h dz=%b busy=%b op=%b want q=%h r=%h dz=%b idle",
                             nm, bus.quotient, bus.remainder, bus.divZero, bus.busy,
                             bus.operation, e.q, e.r, e.dz);
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", nm, dones);
            sb.delete();
        end
        if (!e.dz) begin
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s iter_drive: got %0d bad cycles want 0", nm, bad);
            end
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.divZero, bus.quotient, bus.remainder,
             bus.aluSrc1, bus.aluSrc2, bus.invertA, bus.invertB, bus.operation} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h src1=%h op=%b want all 0",
                     bus.busy, bus.done, bus.divZero, bus.quotient, bus.remainder,
                     bus.aluSrc1, bus.operation);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_div(31'd100, 31'd7, 0, 0, "div_100_7");
        do_div(31'd5, 31'd0, 0, 0, "div_by_zero");
        do_div(31'h7FFFFFFF, 31'd1, 0, 0, "div_max_1");
        do_div(31'd3, 31'd10, 0, 0, "div_3_10");
        do_div(31'h7FFFFFFF, 31'h7FFFFFFF, 0, 0, "div_max_max");
    endtask

    task automatic test_busy_start();
        do_div(31'd100, 31'd7, 5, 32, "start_busy");
        do_div(31'd100, 31'd7, 33, 0, "start_done");
    endtask

    task automatic test_random();
        logic [30:0] a;
        logic [30:0] b;
        for (int i = 0; i < 4; i++) begin
            a = 31'($urandom);
            b = 31'($urandom_range(1, 65535));
            do_div(a, b, 0, 0, "random");
        end
    endtask

    task automatic test_rst_mid();
        int spurious;
        spurious = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 31'd100;
        bus.divisor  = 31'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.divZero, bus.quotient, bus.remainder,
             bus.aluSrc1, bus.aluSrc2, bus.invertB, bus.operation} !== '0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b q=%h r=%h src1=%h op=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.aluSrc1, bus.operation);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (bus.done === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_mid_done: got %0d done pulses want 0", spurious);
        end
        do_div(31'd9, 31'd3, 0, 0, "after_rst");
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_busy_start();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
